// File: rtl/io_pwr_seq_pkg.sv
// io_pwr_seq_pkg: shared state encoding and default timing constants for the
// pad-ring power sequencer.
package io_pwr_seq_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 256;
  localparam int STEP_CYCLES_DEF     = 16;
  localparam int N_BANKS_DEF         = 4;

  typedef enum logic [2:0] {
    OFF,
    DEB,
    IE_ON,
    OE_ON,
    RUN,
    SHDN
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/io_pwr_seq_sync.sv
// io_pwr_seq_sync: parameterized-width 2-flop synchronizer with synchronous
// active-high reset.
module io_pwr_seq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta;

  // two-stage capture of asynchronous supply-good levels
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      dout <= '0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/io_pwr_seq.sv
// io_pwr_seq: core-side pad-ring power sequencer. Debounces the supply-good
// indications, brings IE then per-bank OE_EN up in order, releases core reset,
// and tears down in reverse on supply loss. All outputs are registered Moore
// outputs computed from the next state.
// Optional build macro: IO_PWR_SEQ_ASIG_ISO_EN adds the ASIG_ISO output.
//
//   state | meaning
//   OFF   | pads off, core in reset, waiting for all supplies good
//   DEB   | supplies good, debounce counter running
//   IE_ON | input enables on, one step
//   OE_ON | output enables added one bank per step
//   RUN   | pads live, core reset released
//   SHDN  | drivers off, IE held for one step before OFF
module io_pwr_seq
  import io_pwr_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int STEP_CYCLES     = STEP_CYCLES_DEF,
  parameter int N_BANKS         = N_BANKS_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_BANKS-1:0] DVDD_OK,
  input  logic               VDD_OK,
  input  logic               FAULT_CLR,
  output logic [N_BANKS-1:0] IE,
  output logic [N_BANKS-1:0] OE_EN,
  output logic               CORE_RST,
  output logic               SEQ_DONE,
  output logic               FAULT
`ifdef IO_PWR_SEQ_ASIG_ISO_EN
  ,
  output logic               ASIG_ISO
`endif
);

  localparam int CW = $clog2(max_int(DEBOUNCE_CYCLES, STEP_CYCLES));
  localparam int BW = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;

  logic [N_BANKS:0]   ok_sync;
  logic               all_ok;
  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [BW-1:0]      bank, bank_nxt;
  logic               step_done, deb_done;
  logic [N_BANKS-1:0] ie_nxt, oe_nxt;
  logic               core_rst_nxt, seq_done_nxt, fault_nxt;

  io_pwr_seq_sync #(.WIDTH(N_BANKS + 1)) u_sync (
    .clk  (CLK),
    .rst  (RST),
    .din  ({VDD_OK, DVDD_OK}),
    .dout (ok_sync)
  );

  assign all_ok    = &ok_sync;
  assign step_done = (cnt == CW'(STEP_CYCLES - 1));
  assign deb_done  = (cnt == CW'(DEBOUNCE_CYCLES - 1));

  // next state, step counter, bank index and registered-output values
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    bank_nxt  = bank;
    unique case (state)
      OFF: begin
        cnt_nxt = '0;
        if (all_ok) state_nxt = DEB;
      end
      DEB: begin
        if (!all_ok)       state_nxt = OFF;
        else if (deb_done) state_nxt = IE_ON;
      end
      IE_ON: begin
        if (!all_ok) begin
          state_nxt = SHDN;
        end else if (step_done) begin
          state_nxt = OE_ON;
          bank_nxt  = '0;
        end
      end
      OE_ON: begin
        if (!all_ok) begin
          state_nxt = SHDN;
        end else if (step_done) begin
          if (bank == BW'(N_BANKS - 1)) begin
            state_nxt = RUN;
          end else begin
            bank_nxt = bank + BW'(1);
            cnt_nxt  = '0;
          end
        end
      end
      RUN: begin
        cnt_nxt = '0;
        if (!all_ok) state_nxt = SHDN;
      end
      SHDN: begin
        if (step_done) state_nxt = OFF;
      end
      default: begin
        state_nxt = OFF;
        cnt_nxt   = '0;
      end
    endcase
    if (state_nxt != state) cnt_nxt = '0;

    ie_nxt = '0;
    oe_nxt = '0;
    if (state_nxt inside {IE_ON, OE_ON, RUN, SHDN}) ie_nxt = '1;
    if (state_nxt == RUN) oe_nxt = '1;
    if (state_nxt == OE_ON) begin
      for (int i = 0; i < N_BANKS; i++) oe_nxt[i] = (i <= int'(bank_nxt));
    end
    core_rst_nxt = (state_nxt != RUN);
    seq_done_nxt = (state_nxt == RUN);

    // a loss in RUN outranks a coincident clear
    fault_nxt = FAULT;
    if (FAULT_CLR) fault_nxt = 1'b0;
    if (state == RUN && state_nxt == SHDN) fault_nxt = 1'b1;
  end

  // state, counters and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= OFF;
      cnt      <= '0;
      bank     <= '0;
      IE       <= '0;
      OE_EN    <= '0;
      CORE_RST <= 1'b1;
      SEQ_DONE <= 1'b0;
      FAULT    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bank     <= bank_nxt;
      IE       <= ie_nxt;
      OE_EN    <= oe_nxt;
      CORE_RST <= core_rst_nxt;
      SEQ_DONE <= seq_done_nxt;
      FAULT    <= fault_nxt;
    end
  end

`ifdef IO_PWR_SEQ_ASIG_ISO_EN
  // analog isolation released only while the pads are live
  always_ff @(posedge CLK) begin
    if (RST) ASIG_ISO <= 1'b1;
    else     ASIG_ISO <= (state_nxt != RUN);
  end
`endif

endmodule

// File: tb/tb_io_pwr_seq.sv
// tb_io_pwr_seq: directed scenarios plus randomized supply activity, checked
// every cycle against a timing model built from elapsed-time arithmetic.
module tb_io_pwr_seq;

  localparam int D      = 256;
  localparam int S      = 16;
  localparam int N      = 4;
  localparam int RUN_AT = D + S * (N + 1);

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = 2;

  logic         CLK = 1'b0;
  logic         RST;
  logic [N-1:0] DVDD_OK;
  logic         VDD_OK;
  logic         FAULT_CLR;
  logic [N-1:0] IE;
  logic [N-1:0] OE_EN;
  logic         CORE_RST;
  logic         SEQ_DONE;
  logic         FAULT;
`ifdef IO_PWR_SEQ_ASIG_ISO_EN
  logic         ASIG_ISO;
`endif

  io_pwr_seq #(.DEBOUNCE_CYCLES(D), .STEP_CYCLES(S), .N_BANKS(N)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DVDD_OK   (DVDD_OK),
    .VDD_OK    (VDD_OK),
    .FAULT_CLR (FAULT_CLR),
    .IE        (IE),
    .OE_EN     (OE_EN),
    .CORE_RST  (CORE_RST),
    .SEQ_DONE  (SEQ_DONE),
    .FAULT     (FAULT)
`ifdef IO_PWR_SEQ_ASIG_ISO_EN
    ,
    .ASIG_ISO  (ASIG_ISO)
`endif
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: delay line for the synchronizer, then elapsed time
  bit m_p1, m_p2;
  int m_mode, m_el, m_dn, m_noe;
  bit m_fault, m_run;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit raw_ok();
    return VDD_OK & (&DVDD_OK);
  endfunction

  task automatic model_step(input bit raw, input bit clr, input bit rst);
    bit ok, set;
    set = 1'b0;
    if (rst) begin
      m_p1 = 0; m_p2 = 0; m_mode = M_IDLE; m_el = 0; m_dn = 0; m_fault = 0;
    end else begin
      ok = m_p2; m_p2 = m_p1; m_p1 = raw;
      case (m_mode)
        M_IDLE: if (ok) begin m_mode = M_UP; m_el = 0; end
        M_UP: begin
          if (ok) begin
            if (m_el < 100000) m_el++;
          end else if (m_el < D) begin
            m_mode = M_IDLE;
          end else begin
            set = (m_el >= RUN_AT);
            m_mode = M_DOWN;
            m_dn = 0;
          end
        end
        default: begin
          m_dn++;
          if (m_dn == S) m_mode = M_IDLE;
        end
      endcase
      if (set) m_fault = 1'b1;
      else if (clr) m_fault = 1'b0;
    end
    m_run = (m_mode == M_UP) && (m_el >= RUN_AT);
    m_noe = 0;
    if (m_mode == M_UP && m_el >= D + S) m_noe = ((m_el - D) / S > N) ? N : (m_el - D) / S;
  endtask

  task automatic tick();
    logic [31:0] exp_ie;
    @(posedge CLK);
    model_step(raw_ok(), FAULT_CLR, RST);
    #1;
    exp_ie = (m_mode == M_DOWN || (m_mode == M_UP && m_el >= D)) ? 32'hF : 32'h0;
    chk("IE", 32'(IE), exp_ie);
    chk("OE_EN", 32'(OE_EN), (32'd1 << m_noe) - 32'd1);
    chk("CORE_RST", 32'(CORE_RST), 32'(!m_run));
    chk("SEQ_DONE", 32'(SEQ_DONE), 32'(m_run));
    chk("FAULT", 32'(FAULT), 32'(m_fault));
`ifdef IO_PWR_SEQ_ASIG_ISO_EN
    chk("ASIG_ISO", 32'(ASIG_ISO), 32'(!m_run));
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic supply(input bit v, input logic [N-1:0] dv);
    VDD_OK  = v;
    DVDD_OK = dv;
  endtask

  task automatic wait_noe(input int target, input int budget);
    for (int i = 0; i < budget && m_noe != target; i++) tick();
    chk("wait_oe", 32'(m_noe), 32'(target));
  endtask

  task automatic wait_run(input int budget);
    for (int i = 0; i < budget && !m_run; i++) tick();
    chk("wait_run", 32'(m_run), 32'd1);
  endtask

  task automatic pulse_clr();
    FAULT_CLR = 1'b1; tick(); FAULT_CLR = 1'b0;
  endtask

  initial begin
    RST = 1'b1; FAULT_CLR = 1'b0; supply(1'b0, '0);
    m_mode = M_IDLE; m_el = 0; m_dn = 0; m_fault = 0; m_p1 = 0; m_p2 = 0;
    run(3);
    RST = 1'b0;
    run(2);
    chk("rst_core", 32'(CORE_RST), 32'd1);
    chk("rst_ie", 32'(IE), 32'd0);

    // power-up: edge e is the e-th tick after raising the supplies
    supply(1'b1, '1);
    for (int e = 0; e <= 340; e++) begin
      tick();
      if (e == 257) chk("pu_ie_pre", 32'(IE), 32'h0);
      if (e == 258) chk("pu_ie", 32'(IE), 32'hF);
      if (e == 274) chk("pu_oe0", 32'(OE_EN), 32'h1);
      if (e == 290) chk("pu_oe1", 32'(OE_EN), 32'h3);
      if (e == 306) chk("pu_oe2", 32'(OE_EN), 32'h7);
      if (e == 321) chk("pu_oe3_pre", 32'(OE_EN), 32'h7);
      if (e == 322) chk("pu_oe3", 32'(OE_EN), 32'hF);
      if (e == 337) chk("pu_done_pre", 32'(SEQ_DONE), 32'd0);
      if (e == 338) chk("pu_done", 32'(SEQ_DONE), 32'd1);
      if (e == 338) chk("pu_core", 32'(CORE_RST), 32'd0);
    end

    // loss in RUN
    supply(1'b0, '1);
    for (int e = 0; e <= 20; e++) begin
      tick();
      if (e == 1) chk("loss_done_pre", 32'(SEQ_DONE), 32'd1);
      if (e == 2) chk("loss_fault", 32'(FAULT), 32'd1);
      if (e == 2) chk("loss_oe", 32'(OE_EN), 32'd0);
      if (e == 17) chk("loss_ie_pre", 32'(IE), 32'hF);
      if (e == 18) chk("loss_ie", 32'(IE), 32'h0);
    end
    run(10);
    chk("fault_sticky", 32'(FAULT), 32'd1);
    pulse_clr();
    chk("fault_clr", 32'(FAULT), 32'd0);

    // debounce abort: DVDD_OK[2] drops for 3 cycles at edge 100
    supply(1'b1, '1);
    run(100);
    supply(1'b1, 4'b1011);
    run(3);
    supply(1'b1, '1);
    for (int e = 0; e <= 260; e++) begin
      tick();
      if (e == 257) chk("deb_ie_pre", 32'(IE), 32'h0);
      if (e == 258) chk("deb_ie", 32'(IE), 32'hF);
    end

    // loss during OE_ON at OE_EN=3, supply restored mid-SHDN
    wait_noe(2, 200);
    supply(1'b1, 4'b0111);
    run(6);
    supply(1'b1, '1);
    run(14);
    chk("shdn_fault", 32'(FAULT), 32'd0);
    wait_noe(3, 600);

    // reset at OE_EN=7
    RST = 1'b1;
    tick();
    chk("rst_mid_oe", 32'(OE_EN), 32'd0);
    RST = 1'b0;
    wait_run(600);

    // FAULT_CLR coincident with the fault-setting edge
    supply(1'b0, '1);
    run(2);
    FAULT_CLR = 1'b1;
    tick();
    FAULT_CLR = 1'b0;
    chk("set_wins", 32'(FAULT), 32'd1);
    run(30);

    // randomized supply activity
    for (int seg = 0; seg < 40; seg++) begin
      int dur;
      if ($urandom_range(0, 9) < 7) supply(1'b1, '1);
      else supply(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      dur = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 400);
      if ($urandom_range(0, 14) == 0) begin
        RST = 1'b1; tick(); RST = 1'b0;
      end
      for (int i = 0; i < dur; i++) begin
        FAULT_CLR = ($urandom_range(0, 49) == 0);
        tick();
      end
      FAULT_CLR = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_pwr_seq.md
# io_pwr_seq

Core-side power sequencer for the pad ring: watches the supply-good indications behind the DVDD/DVSS pad cells and drives pad enables from the core. The pad cells supply power; this block consumes their status and brings the digital I/O banks up in a fixed order. On supply loss it tears them down in reverse order. It sits between the per-bank supply detectors and the core reset/pad-enable distribution.

## Interface
- DEBOUNCE_CYCLES, 256, cycles all supplies must stay good before sequencing starts (>=2)
- STEP_CYCLES, 16, cycles per sequencing step (>=1)
- N_BANKS, 4, number of I/O pad banks (>=1)

- CLK  in  1  single clock
- RST  in  1  synchronous, active-high reset
- DVDD_OK  in  N_BANKS  per-bank DVDD-good, asynchronous
- VDD_OK  in  1  core VDD-good, asynchronous
- FAULT_CLR  in  1  clears FAULT (single-cycle pulse)
- IE  out  N_BANKS  pad input enables
- OE_EN  out  N_BANKS  pad output-driver enables
- CORE_RST  out  1  core reset, active-high
- SEQ_DONE  out  1  sequence complete, pads live
- FAULT  out  1  sticky: supply lost while in RUN
- ASIG_ISO  out  1  analog pad isolation (present only with the macro)

## Operation
- DVDD_OK and VDD_OK each pass through a 2-flop synchronizer. The synchronizers reset to 0.
- all_ok = synchronized VDD_OK AND all synchronized DVDD_OK bits.
- All outputs are registered and decoded from the state, so the block is a Moore machine.
- States and transitions:
  - OFF: IE=0, OE_EN=0, CORE_RST=1, SEQ_DONE=0. Go to DEB when all_ok=1.
  - DEB: same outputs as OFF. Counter runs for DEBOUNCE_CYCLES cycles, then go to IE_ON. If all_ok=0, go to OFF and clear the counter.
  - IE_ON: IE all ones. Stay STEP_CYCLES cycles, then go to OE_ON with bank index 0.
  - OE_ON: OE_EN[k] sets on entry to step k and bits 0..k stay set. Each step lasts STEP_CYCLES cycles. After step N_BANKS-1, go to RUN.
  - RUN: CORE_RST=0, SEQ_DONE=1.
  - SHDN: OE_EN=0, CORE_RST=1, SEQ_DONE=0, IE held all ones. Stay STEP_CYCLES cycles, then go to OFF (IE=0).
- all_ok=0 in IE_ON, OE_ON or RUN sends the machine to SHDN.
- Entering SHDN from RUN sets FAULT.
- all_ok returning during SHDN is ignored. The machine always completes SHDN to OFF and then re-debounces.
- FAULT_CLR clears FAULT. If a set and a clear happen in the same cycle, the set wins.
- Counter width = $clog2 of the larger of DEBOUNCE_CYCLES and STEP_CYCLES. The counter clears on every state change. The bank index is $clog2(N_BANKS) wide, minimum 1 bit.
- RST mid-sequence forces OFF outputs on the next edge, clears FAULT and clears the synchronizers.

## Timing
- Edge numbering: raw all_ok rises before edge 0 and stays high.
  - Synchronized value is visible after edge 1.
  - State = DEB from edge 2.
- IE rises at edge 2+DEBOUNCE_CYCLES.
- OE_EN[k] rises at edge 2+DEBOUNCE_CYCLES+STEP_CYCLES*(k+1).
- CORE_RST falls and SEQ_DONE rises at edge 2+DEBOUNCE_CYCLES+STEP_CYCLES*(N_BANKS+1).
- Loss: raw falls before edge 0.
  - OE_EN, SEQ_DONE fall, CORE_RST and FAULT rise at edge 2.
  - IE falls at edge 2+STEP_CYCLES.
- A raw glitch shorter than one cycle may be missed. That is acceptable.

## Configuration
- IO_PWR_SEQ_ASIG_ISO_EN defined: ASIG_ISO port exists.
  - ASIG_ISO=1 in every state except RUN.
  - Reset value is 1.
  - ASIG_ISO rises on the same edge as SEQ_DONE falls.
- IO_PWR_SEQ_ASIG_ISO_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package io_pwr_seq_pkg holds:
  - state enum (OFF, DEB, IE_ON, OE_ON, RUN, SHDN)
  - default DEBOUNCE_CYCLES and STEP_CYCLES constants
- Sub-module io_pwr_seq_sync: parameterized-width 2-flop synchronizer with synchronous reset. One instance covers N_BANKS+1 bits.

## Test plan
- Power-up, defaults: raise VDD_OK and all DVDD_OK before edge 0 and hold them.
  - IE=4'hF at edge 258.
  - OE_EN=1,3,7,F at edges 274, 290, 306, 322.
  - CORE_RST=0, SEQ_DONE=1 at edge 338.
  - FAULT=0 throughout.
- Debounce abort: drop DVDD_OK[2] for 3 cycles at edge 100.
  - Stays in OFF/DEB, IE stays 0.
  - Full sequence restarts and IE rises 258 edges after the supply returns.
- Loss in RUN: drop VDD_OK.
  - Two edges later OE_EN=0, CORE_RST=1, SEQ_DONE=0, FAULT=1.
  - IE=0 sixteen edges after that.
  - FAULT stays 1 until a FAULT_CLR pulse.
- Loss during OE_ON (OE_EN=3): returns to OFF via SHDN with FAULT=0. Supply restored mid-SHDN does not shorten SHDN.
- RST asserted at OE_EN=7 → next edge OFF outputs, FAULT=0. FAULT_CLR coincident with a new RUN loss → FAULT=1.
- With IO_PWR_SEQ_ASIG_ISO_EN: ASIG_ISO=1 from reset, 0 exactly while SEQ_DONE=1.
